sao_stat_eo_acc: RTL

- Stage-2 consumer of the SAO statistics pipeline register.
- Takes per-pixel clipped differences (n_diff) plus per-pixel edge-offset category for n_pix pixels per beat.
- Accumulates a per-category sum and count over one CTB/component pass.
- On the last beat (not_end low), presents the final statistics to the offset-decision stage through a valid/ready handshake.

---
 rtl/sao_stat_eo_acc.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sao_stat_eo_acc.sv
// SAO edge-offset statistics accumulator.
// Collects per-category (EO class 1..4) difference sums and pixel counts
// over one CTB/component pass, then hands the totals to the offset-decision
// stage with a valid/ready handshake. Per-pixel category decode lives in
// sao_eo_lane; the top reduces the lanes and runs a small IDLE/ACC/HOLD FSM.

// Per-pixel decode: routes the sign-extended difference to its category slot.
module sao_eo_lane #(
    parameter int diff_clip_bit = 4,
    parameter int SUM_W         = 18
) (
    input  logic signed [diff_clip_bit:0] diff,
    input  logic        [2:0]             cat,
    output logic        [3:0][SUM_W-1:0]  dsum,
    output logic        [3:0]             hit
);

    logic [SUM_W-1:0] diff_ext;

    assign diff_ext = {{(SUM_W-diff_clip_bit-1){diff[diff_clip_bit]}}, diff};

    // Categories 5..7 match no slot and so behave like category 0.
    always_comb begin
        hit  = '0;
        dsum = '0;
        for (int k = 0; k < 4; k++) begin
            hit[k]  = (cat == 3'(k + 1));
            dsum[k] = hit[k] ? diff_ext : '0;
        end
    end

endmodule

module sao_stat_eo_acc #(
    parameter int diff_clip_bit = 4,
    parameter int n_pix         = 4,
    parameter int SUM_W         = 18,
    parameter int CNT_W         = 13
) (
    input  logic                                   clk,
    input  logic                                   arst,
    input  logic                                   en,
    input  logic                                   isWorking_stat_r1,
    input  logic                                   wait_forPre_r1,
    input  logic                                   not_end_r1,
    input  logic signed [n_pix-1:0][diff_clip_bit:0] n_diff_r1,
    input  logic        [n_pix-1:0][2:0]           eo_cat,
    input  logic        [1:0]                      cIdx_r1,
    output logic                                   in_ready,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic signed [3:0][SUM_W-1:0]           sum_o,
    output logic        [3:0][CNT_W-1:0]           cnt_o,
    output logic        [1:0]                      cIdx_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0] state;

    logic [n_pix-1:0][3:0][SUM_W-1:0] lane_sum;
    logic [n_pix-1:0][3:0]            lane_hit;

    logic [3:0][SUM_W-1:0] d_sum;
    logic [3:0][CNT_W-1:0] d_cnt;
    logic [3:0][SUM_W-1:0] acc_sum;
    logic [3:0][CNT_W-1:0] acc_cnt;
    logic [3:0][SUM_W-1:0] nxt_sum;
    logic [3:0][CNT_W-1:0] nxt_cnt;
    logic [1:0]            cidx_r;
    logic                  beat;
    logic                  first;

    genvar gi;
    generate
        for (gi = 0; gi < n_pix; gi++) begin : g_lane
            sao_eo_lane #(
                .diff_clip_bit(diff_clip_bit),
                .SUM_W        (SUM_W)
            ) u_lane (
                .diff(n_diff_r1[gi]),
                .cat (eo_cat[gi]),
                .dsum(lane_sum[gi]),
                .hit (lane_hit[gi])
            );
        end
    endgenerate

    // State-only decodes keep in_ready/out_valid free of input paths.
    assign in_ready  = (state != S_HOLD);
    assign out_valid = (state == S_HOLD);
    assign beat      = en & isWorking_stat_r1 & ~wait_forPre_r1 & in_ready;
    assign first     = (state == S_IDLE);

    // Reduce the lanes into per-category beat deltas.
    always_comb begin
        d_sum = '0;
        d_cnt = '0;
        for (int i = 0; i < n_pix; i++) begin
            for (int k = 0; k < 4; k++) begin
                d_sum[k] = d_sum[k] + lane_sum[i][k];
                d_cnt[k] = d_cnt[k] + CNT_W'(lane_hit[i][k]);
            end
        end
    end

    // First beat of a pass starts from zero so stale totals never leak in.
    always_comb begin
        nxt_sum = '0;
        nxt_cnt = '0;
        for (int k = 0; k < 4; k++) begin
            nxt_sum[k] = (first ? '0 : acc_sum[k]) + d_sum[k];
            nxt_cnt[k] = (first ? '0 : acc_cnt[k]) + d_cnt[k];
        end
    end

    // Pass FSM: IDLE -> ACC on a non-final beat, either -> HOLD on the final beat.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_ACC: if (beat) state <= not_end_r1 ? S_ACC : S_HOLD;
                S_HOLD:        if (out_ready) state <= S_IDLE;
                default:       state <= S_IDLE;
            endcase
        end
    end

    // Running accumulators; cleared on the final beat so the next pass is clean.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            acc_sum <= '0;
            acc_cnt <= '0;
        end else if (beat) begin
            if (not_end_r1) begin
                acc_sum <= nxt_sum;
                acc_cnt <= nxt_cnt;
            end else begin
                acc_sum <= '0;
                acc_cnt <= '0;
            end
        end
    end

    // Component captured on the first beat; later cIdx changes are ignored.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) cidx_r <= '0;
        else if (beat && first) cidx_r <= cIdx_r1;
    end

    // Output registers load once per pass and hold through HOLD.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sum_o  <= '0;
            cnt_o  <= '0;
            cIdx_o <= '0;
        end else if (beat && !not_end_r1) begin
            sum_o  <= nxt_sum;
            cnt_o  <= nxt_cnt;
            cIdx_o <= first ? cIdx_r1 : cidx_r;
        end
    end

endmodule
